// File: rtl/traffic_pkg.sv
// Shared encodings and default timing constants for the traffic-light controller
// and its phase timer.
package traffic_pkg;

  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_PD   = 2'b01;
  localparam logic [1:0] PH_NOPD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } timer_state_t;

  localparam int unsigned DEF_TICK_DIV = 32'd50_000_000;
  localparam int unsigned DEF_PD_SEC   = 32'd15;
  localparam int unsigned DEF_NOPD_SEC = 32'd30;
  localparam int unsigned DEF_CNT_W    = 32'd8;

  // Largest value the two-digit countdown display can show.
  localparam int unsigned BCD_MAX = 32'd99;

endpackage

// File: rtl/phase_timer_bin2bcd.sv
// Combinational binary to two-digit BCD converter for the countdown display;
// values above 99 saturate to 9/9.
module bin2bcd
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic [CNT_W-1:0] bin,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  logic [31:0] value;

  // Widen first so the 99 compare and the divide are width-independent.
  always_comb begin
    value = 32'(bin);
    if (value > BCD_MAX) begin
      tens = 4'd9;
      ones = 4'd9;
    end else begin
      tens = 4'(value / 32'd10);
      ones = 4'(value % 32'd10);
    end
  end

endmodule

// File: rtl/phase_timer.sv
// Phase duration timer for the traffic-light FSM: counts whole seconds of a pedestrian or
// vehicle phase and pulses finish. Define PHASE_TIMER_BCD_EN to add registered BCD digit outputs.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned PD_SEC   = DEF_PD_SEC,
  parameter int unsigned NOPD_SEC = DEF_NOPD_SEC,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_pd,
  input  logic             start_nopd,
  output logic             finish,
  output logic             busy,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] sec_left
`ifdef PHASE_TIMER_BCD_EN
  ,
  output logic [3:0]       sec_tens,
  output logic [3:0]       sec_ones
`endif
);

  localparam int unsigned      PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 32'd1);
  localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
  localparam logic [CNT_W-1:0] SEC_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] SEC_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] PD_LOAD  = CNT_W'(PD_SEC);
  localparam logic [CNT_W-1:0] NOPD_LOAD = CNT_W'(NOPD_SEC);

  timer_state_t     state, state_nx;
  logic [PRE_W-1:0] prescaler, prescaler_nx;
  logic [CNT_W-1:0] sec_left_nx;
  logic             busy_nx, finish_nx;
  logic [1:0]       phase_nx;

  // State and every output register; reset aborts any phase without a finish pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      prescaler <= PRE_ZERO;
      sec_left  <= SEC_ZERO;
      busy      <= 1'b0;
      finish    <= 1'b0;
      phase     <= PH_IDLE;
    end else begin
      state     <= state_nx;
      prescaler <= prescaler_nx;
      sec_left  <= sec_left_nx;
      busy      <= busy_nx;
      finish    <= finish_nx;
      phase     <= phase_nx;
    end
  end

  // Next-state logic: a start in any state (including DONE) reloads, pedestrian wins a tie.
  always_comb begin
    state_nx     = state;
    prescaler_nx = prescaler;
    sec_left_nx  = sec_left;
    busy_nx      = busy;
    finish_nx    = 1'b0;
    phase_nx     = phase;
    if (start_pd || start_nopd) begin
      state_nx     = ST_RUN;
      prescaler_nx = PRE_ZERO;
      busy_nx      = 1'b1;
      if (start_pd) begin
        sec_left_nx = PD_LOAD;
        phase_nx    = PH_PD;
      end else begin
        sec_left_nx = NOPD_LOAD;
        phase_nx    = PH_NOPD;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (prescaler == PRE_MAX) begin
            prescaler_nx = PRE_ZERO;
            // <= also covers a corrupted zero count so sec_left never wraps.
            if (sec_left <= SEC_ONE) begin
              sec_left_nx = SEC_ZERO;
              busy_nx     = 1'b0;
              finish_nx   = 1'b1;
              state_nx    = ST_DONE;
            end else begin
              sec_left_nx = sec_left - SEC_ONE;
            end
          end else begin
            prescaler_nx = prescaler + PRE_W'(32'd1);
          end
        end
        ST_DONE: begin
          state_nx     = ST_IDLE;
          prescaler_nx = PRE_ZERO;
          phase_nx     = PH_IDLE;
        end
        ST_IDLE: begin
          prescaler_nx = PRE_ZERO;
          sec_left_nx  = SEC_ZERO;
          busy_nx      = 1'b0;
          phase_nx     = PH_IDLE;
        end
        default: begin
          state_nx     = ST_IDLE;
          prescaler_nx = PRE_ZERO;
          sec_left_nx  = SEC_ZERO;
          busy_nx      = 1'b0;
          phase_nx     = PH_IDLE;
        end
      endcase
    end
  end

`ifdef PHASE_TIMER_BCD_EN
  logic [3:0] bcd_tens, bcd_ones;

  bin2bcd #(.CNT_W(CNT_W)) u_bin2bcd (
    .bin  (sec_left),
    .tens (bcd_tens),
    .ones (bcd_ones)
  );

  // Display digits trail sec_left by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else begin
      sec_tens <= bcd_tens;
      sec_ones <= bcd_ones;
    end
  end
`endif

endmodule
